// File: rtl/alu_op_sequencer.sv
// Purpose: sequences single ALU operations: latches operand into DR, strobes a
//          one-hot ALU select, captures the result into AC and a response reg.
// Latency: res_valid 1 cycle after accept (LDA/illegal), 2 (single-cycle ops),
//          3 (MUL/DIV). Backpressure: result held in RESP until res_ready;
//          cmd_ready is high only in IDLE, so no new command while a result waits.
// Ports:   clk/rst_n (sync, active-low); cmd_* command handshake; alu_* drive
//          and sample an external combinational ALU; res_* result handshake;
//          ac_value mirrors the accumulator.
module alu_op_sequencer #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_ac,
  output logic [WIDTH-1:0] alu_dr,
  output logic [13:0]      alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_illegal,
  output logic [WIDTH-1:0] ac_value
);

  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_LDA = 4'd14;
  localparam logic [3:0] OP_ILL = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic             cnt_q, cnt_d;
  logic [13:0]      sel_q, sel_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_ill_q, res_ill_d;

  always_comb begin
    state_d    = state_q;
    ac_d       = ac_q;
    dr_d       = dr_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    res_ill_d  = res_ill_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_opcode == OP_ILL) begin
            // Report the untouched accumulator so the consumer still gets a value.
            res_data_d = ac_q;
            res_ovf_d  = 1'b0;
            res_ill_d  = 1'b1;
            state_d    = S_RESP;
          end else if (cmd_opcode == OP_LDA) begin
            ac_d       = cmd_operand;
            res_data_d = cmd_operand;
            res_ovf_d  = 1'b0;
            res_ill_d  = 1'b0;
            state_d    = S_RESP;
          end else begin
            dr_d    = cmd_operand;
            sel_d   = 14'd1 << cmd_opcode;
            // MUL/DIV get one extra cycle for the ALU to settle.
            cnt_d   = (cmd_opcode == OP_MUL) || (cmd_opcode == OP_DIV);
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q) begin
          cnt_d = 1'b0;
        end else begin
          ac_d       = alu_result;
          res_data_d = alu_result;
          res_ovf_d  = alu_ovf;
          res_ill_d  = 1'b0;
          sel_d      = '0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        cnt_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ac_q       <= '0;
      dr_q       <= '0;
      cnt_q      <= 1'b0;
      sel_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ac_q       <= ac_d;
      dr_q       <= dr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      res_ill_q  <= res_ill_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_RESP);
  assign alu_ac      = ac_q;
  assign alu_dr      = dr_q;
  assign alu_sel     = sel_q;
  assign res_data    = res_data_q;
  assign res_ovf     = res_ovf_q;
  assign res_illegal = res_ill_q;
  assign ac_value    = ac_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int W = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode = 4'd0;
  logic [W-1:0]  cmd_operand = '0;
  logic [W-1:0]  alu_ac, alu_dr, alu_result;
  logic [13:0]   alu_sel;
  logic          alu_ovf;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic          res_ovf, res_illegal;
  logic [W-1:0]  ac_value;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .res_illegal(res_illegal),
    .ac_value(ac_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
    logic         ill;
    int           due;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] ac_model = '0;
  int           hold_req = 0;
  bit           in_flight = 0;

  // Behavioural ALU: returns {ovf, result}. Overflow means the true result
  // does not fit (carry/borrow, or a product reaching the sign bit).
  function automatic logic [W:0] alu_fn(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned full;
    logic [W-1:0] r;
    logic o = 1'b0;
    case (op)
      0:  begin full = ua + ub; o = (full >> W) != 0; end
      1:  begin full = ua - ub; o = ua < ub; end
      2:  begin full = ua * ub; o = (full >> (W - 1)) != 0; end
      3:  begin
            if (ub == 0) begin full = '1; o = 1'b1; end
            else full = ua / ub;
          end
      4:  full = ua & ub;
      5:  full = ua | ub;
      6:  full = ua ^ ub;
      7:  full = ~ua;
      8:  begin full = ua + 1; o = (full >> W) != 0; end
      9:  begin full = ua - 1; o = (ua == 0); end
      default: full = ua ^ ub ^ longint'(op);
    endcase
    r = full[W-1:0];
    return {o, r};
  endfunction

  function automatic int sel_to_op(input logic [13:0] s);
    int op = 0;
    for (int i = 0; i < 14; i++) if (s[i]) op = i;
    return op;
  endfunction

  assign {alu_ovf, alu_result} = (alu_sel == 14'd0) ? '0 : alu_fn(sel_to_op(alu_sel), alu_ac, alu_dr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation when a result first appears, checks values
  // and latency, then checks stability while backpressured.
  initial begin
    exp_t cur;
    int   hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_flight = 0;
        res_ready = 1'b0;
      end else if (res_valid) begin
        chk("cmd_ready_low_in_resp", cmd_ready, 0);
        if (!in_flight) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
            cur.data = res_data; cur.ovf = res_ovf; cur.ill = res_illegal; cur.due = cyc;
          end else begin
            cur = sb.pop_front();
            chk("res_data", res_data, cur.data);
            chk("res_ovf", res_ovf, cur.ovf);
            chk("res_illegal", res_illegal, cur.ill);
            chk("latency", cyc, cur.due);
          end
          in_flight = 1;
          hold = hold_req;
          hold_req = 0;
        end else begin
          chk("res_data_stable", res_data, cur.data);
          chk("res_ovf_stable", res_ovf, cur.ovf);
          chk("res_illegal_stable", res_illegal, cur.ill);
        end
        if (hold > 0) begin
          res_ready = 1'b0;
          hold--;
        end else begin
          res_ready = ($urandom_range(0, 2) != 0);
        end
        if (res_ready) in_flight = 0;
      end else begin
        res_ready = $urandom_range(0, 1) != 0;
      end
    end
  end

  // Issue one command and check its strobe window against the model.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] v);
    int           n = 0;
    exp_t         e;
    logic [W:0]   ro;
    int           lat;
    int           sw;
    logic [W-1:0] ac_before;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_operand = v;
    ac_before   = ac_model;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    if (op == 4'd15) begin
      e.data = ac_model; e.ill = 1'b1; lat = 1; sw = 0;
    end else if (op == 4'd14) begin
      ac_model = v; e.data = v; lat = 1; sw = 0;
    end else begin
      ro = alu_fn(int'(op), ac_model, v);
      e.data = ro[W-1:0];
      e.ovf = ro[W];
      ac_model = e.data;
      sw = (op == 4'd2 || op == 4'd3) ? 2 : 1;
      lat = sw + 1;
    end
    e.due = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < sw; i++) begin
      if (i > 0) @(negedge clk);
      chk("strobe", alu_sel, 14'd1 << op);
      chk("alu_dr", alu_dr, v);
      chk("alu_ac", alu_ac, ac_before);
    end
    if (sw > 0) @(negedge clk);
    chk("strobe_off", alu_sel, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || in_flight || !cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n;
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ac_value", ac_value, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1'b1;

    // LDA 5 then ADD 3
    issue(4'd14, 19'h00005);
    issue(4'd0, 19'h00003);
    drain();
    chk("add_ac_value", ac_value, 19'h00008);

    // AC=256, MUL 1024
    issue(4'd14, 19'd256);
    issue(4'd2, 19'd1024);
    drain();
    chk("mul_ac_value", ac_value, 19'h40000);

    // Backpressure with a competing command held on cmd_valid
    hold_req = 5;
    issue(4'd0, 19'h00001);
    cmd_valid = 1'b1; cmd_opcode = 4'd14; cmd_operand = 19'h01234;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    chk("bp_held_cycles_ge5", n >= 5, 1);
    drain();
    chk("bp_ac_value", ac_value, 19'h40001);

    // Illegal opcode
    issue(4'd14, 19'h00007);
    issue(4'd15, W'($urandom));
    drain();
    chk("ill_ac_value", ac_value, 19'h00007);

    // Randomised mix
    for (int i = 0; i < 40; i++) issue(4'($urandom_range(0, 15)), W'($urandom));
    drain();
    chk("rand_ac_value", ac_value, ac_model);

    // Reset during MUL execution
    issue(4'd14, 19'h00005);
    drain();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 4'd2; cmd_operand = 19'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_mul_strobe", alu_sel, 14'h0004);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_alu_sel", alu_sel, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_ac_value", ac_value, 0);
    rst_n = 1'b1;
    ac_model = '0;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_no_result", res_valid, 0);

    for (int i = 0; i < 10; i++) issue(4'($urandom_range(0, 15)), W'($urandom));
    drain();
    chk("final_ac_value", ac_value, ac_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
